// File: rtl/stud_dac_wb_if.sv
// Wishbone slave front end for the audio DAC: CTRL/STATUS register bank plus a
// 2-entry sample staging buffer feeding the modulator's handshake.
module stud_dac_wb_if #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned AUDIO_WIDTH   = 16,
    parameter int unsigned VOLUME_WIDTH  = 8,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned WB_SEL_WIDTH  = 4
) (
`ifdef USE_POWER_PINS
    inout  wire                      vccd1,
    inout  wire                      vssd1,
`endif
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [31:0]              wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic [AUDIO_WIDTH-1:0]   fifo_o,
    output logic                     fifo_rdy_o,
    input  logic                     fifo_ack_i,
    input  logic                     fifo_full_i,
    input  logic                     fifo_empty_i,
    output logic                     mode_o,
    output logic                     mute_o,
    output logic                     test_mode_o,
    output logic [1:0]               osr_o,
    output logic [3:0]               test_sine_psc_o,
    output logic [VOLUME_WIDTH-1:0]  volume_o
);

    localparam logic [31:0] CTRL_RESET = 32'h0000_0002;
    localparam logic [31:0] VOL_MASK   = ((32'd1 << VOLUME_WIDTH) - 32'd1) << 16;
    localparam logic [31:0] CTRL_MASK  = 32'h0000_0F1F | VOL_MASK;

    logic                   r_ack;
    logic [31:0]            r_dat;
    logic [31:0]            r_ctrl;
    logic                   r_sel_err;
    logic [1:0]             r_count;
    logic [AUDIO_WIDTH-1:0] r_buf0;
    logic [AUDIO_WIDTH-1:0] r_buf1;

    logic                   w_hit;
    logic                   w_req;
    logic [1:0]             w_off;
    logic                   w_data_wr;
    logic                   w_sel_full;
    logic                   w_sel_lo;
    logic                   w_space;
    logic                   w_fire;
    logic                   w_push2;
    logic                   w_push1;
    logic                   w_sel_bad;
    logic                   w_pop;
    logic                   w_ctrl_wr;
    logic                   w_stat_clr;
    logic [AUDIO_WIDTH-1:0] w_s0;
    logic [AUDIO_WIDTH-1:0] w_s1;
    logic [AUDIO_WIDTH-1:0] w_buf0_nxt;
    logic [AUDIO_WIDTH-1:0] w_buf1_nxt;
    logic [1:0]             w_mid_cnt;
    logic [1:0]             w_count_nxt;
    logic [31:0]            w_ctrl_nxt;
    logic [31:0]            w_status;
    logic [31:0]            w_rdata;
    logic                   w_unused_adr;

    assign w_unused_adr = ^wb_adr_i[1:0];

    assign w_hit      = (wb_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack & w_hit;
    assign w_off      = wb_adr_i[3:2];
    assign w_data_wr  = w_req & wb_we_i & (w_off == 2'd1);
    assign w_sel_full = (wb_sel_i == 4'b1111);
    assign w_sel_lo   = (wb_sel_i == 4'b0011);

    // Space is judged on the registered count only; a same-cycle pop is not credited.
    always_comb begin
        w_space = 1'b1;
        if (w_data_wr) begin
            if (w_sel_full) begin
                w_space = (r_count == 2'd0);
            end else if (w_sel_lo) begin
                w_space = (r_count != 2'd2);
            end
        end
    end

    assign w_fire     = w_req & w_space;
    assign w_push2    = w_fire & w_data_wr & w_sel_full;
    assign w_push1    = w_fire & w_data_wr & w_sel_lo;
    assign w_sel_bad  = w_fire & w_data_wr & ~w_sel_full & ~w_sel_lo;
    assign w_pop      = fifo_ack_i & (r_count != 2'd0);
    assign w_ctrl_wr  = w_fire & wb_we_i & (w_off == 2'd0);
    assign w_stat_clr = w_fire & wb_we_i & (w_off == 2'd2) & wb_sel_i[0] & wb_dat_i[4];

    assign w_s0 = wb_dat_i[AUDIO_WIDTH-1:0];
    assign w_s1 = wb_dat_i[16 +: AUDIO_WIDTH];

    // Pop is applied first, then the push lands behind whatever remains.
    always_comb begin
        w_mid_cnt   = r_count - {1'b0, w_pop};
        w_buf0_nxt  = w_pop ? r_buf1 : r_buf0;
        w_buf1_nxt  = r_buf1;
        w_count_nxt = w_mid_cnt;
        if (w_push2) begin
            w_buf0_nxt  = w_s0;
            w_buf1_nxt  = w_s1;
            w_count_nxt = 2'd2;
        end else if (w_push1) begin
            if (w_mid_cnt == 2'd0) begin
                w_buf0_nxt = w_s0;
            end else begin
                w_buf1_nxt = w_s0;
            end
            w_count_nxt = w_mid_cnt + 2'd1;
        end
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) begin
                w_ctrl_nxt[b*8 +: 8] = wb_dat_i[b*8 +: 8];
            end
        end
        w_ctrl_nxt = w_ctrl_nxt & CTRL_MASK;
    end

    assign w_status = {27'd0, r_sel_err, (r_count == 2'd2), (r_count == 2'd0),
                       fifo_empty_i, fifo_full_i};

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            2'd0:    w_rdata = r_ctrl;
            2'd2:    w_rdata = w_status;
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
            r_ctrl    <= CTRL_RESET;
            r_sel_err <= 1'b0;
            r_count   <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            r_ack   <= w_fire;
            r_count <= w_count_nxt;
            r_buf0  <= w_buf0_nxt;
            r_buf1  <= w_buf1_nxt;
            if (w_fire) begin
                r_dat <= wb_we_i ? 32'd0 : w_rdata;
            end
            if (w_ctrl_wr) begin
                r_ctrl <= w_ctrl_nxt;
            end
            if (w_sel_bad) begin
                r_sel_err <= 1'b1;
            end else if (w_stat_clr) begin
                r_sel_err <= 1'b0;
            end
        end
    end

    assign wb_ack_o        = r_ack;
    assign wb_dat_o        = r_dat;
    assign fifo_rdy_o      = (r_count != 2'd0);
    assign fifo_o          = (r_count != 2'd0) ? r_buf0 : '0;
    assign mode_o          = r_ctrl[0];
    assign mute_o          = r_ctrl[1];
    assign osr_o           = r_ctrl[3:2];
    assign test_mode_o     = r_ctrl[4];
    assign test_sine_psc_o = r_ctrl[11:8];
    assign volume_o        = r_ctrl[16 +: VOLUME_WIDTH];

endmodule

// File: tb/tb_stud_dac_wb_if.sv
// Bench for stud_dac_wb_if: register vector table, hand-written handshake
// sequences, and random traffic checked against a queue-based model.
module tb_stud_dac_wb_if;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [15:0] fifo_o;
    logic        fifo_rdy;
    logic        fifo_ack = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1;
    logic        mode, mute, test_mode;
    logic [1:0]  osr;
    logic [3:0]  psc;
    logic [7:0]  volume;

    int n_pass = 0;
    int n_total = 0;

    stud_dac_wb_if dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(dat), .wb_sel_i(sel), .wb_ack_o(ack), .wb_dat_o(rdat),
        .fifo_o(fifo_o), .fifo_rdy_o(fifo_rdy), .fifo_ack_i(fifo_ack),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .mode_o(mode), .mute_o(mute), .test_mode_o(test_mode), .osr_o(osr),
        .test_sine_psc_o(psc), .volume_o(volume)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ctrl;
    bit          m_sel_err;
    logic [15:0] m_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // One bus transfer; gives up after budget edges without ack.
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input int budget,
                       output logic [31:0] rd, output bit ok, output int waits);
        @(negedge clk);
        adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        ok = 1'b0; waits = 0; rd = '0;
        while (!ok && waits < budget) begin
            @(posedge clk); #1;
            if (ack) begin
                ok = 1'b1;
                rd = rdat;
            end else begin
                waits++;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk); fifo_ack = 1'b1;
        @(posedge clk); #1; fifo_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        m_ctrl = 32'h2; m_sel_err = 0; m_q.delete();
    endtask

    function automatic logic [31:0] ctrl_after(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        return {8'h00, r[23:16], 4'h0, r[11:8], 3'b000, r[4:0]};
    endfunction

    function automatic logic [31:0] status_exp();
        return {27'd0, m_sel_err, m_q.size() == 2, m_q.size() == 0, fifo_empty, fifo_full};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
        logic        exp_ack;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [31:0] rd;
        bit          ok;
        int          waits;

        tbl[0]  = '{BASE + 32'h0, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0002};
        tbl[1]  = '{BASE + 32'h8, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0006};
        tbl[2]  = '{BASE + 32'h4, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0000};
        tbl[3]  = '{BASE + 32'hC, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0000};
        tbl[4]  = '{BASE + 32'hC, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{BASE + 32'h0, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0002};
        tbl[6]  = '{BASE + 32'h0, 1'b1, 32'h00A0_031D, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{BASE + 32'h0, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h00A0_031D};
        tbl[8]  = '{BASE + 32'h0, 1'b1, 32'h0040_0000, 4'h4, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{BASE + 32'h0, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0040_031D};
        tbl[10] = '{BASE + 32'h4, 1'b1, 32'h1234_5678, 4'h1, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{BASE + 32'h8, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0016};
        tbl[12] = '{BASE + 32'h8, 1'b1, 32'h0000_0010, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[13] = '{BASE + 32'h8, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0000_0006};
        tbl[14] = '{32'h4000_0000, 1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{BASE + 32'h0, 1'b1, 32'h0000_0002, 4'hF, 1'b1, 1'b0, 32'h0};

        do_reset();
        #1;
        chk("rst_rdy", fifo_rdy, 1'b0);
        chk("rst_mute", mute, 1'b1);
        chk("rst_ack", ack, 1'b0);
        chk("rst_fifo_o", fifo_o, 16'h0);

        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, 5, rd, ok, waits);
            chk($sformatf("vec%0d_ack", i), ok, tbl[i].exp_ack);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
        end

        // Two-sample write and drain
        bus(BASE + 32'h4, 1'b1, 32'hBEEF_1234, 4'hF, 5, rd, ok, waits);
        chk("two_ack", ok, 1'b1);
        chk("two_rdy", fifo_rdy, 1'b1);
        chk("two_head0", fifo_o, 16'h1234);
        pop();
        chk("two_head1", fifo_o, 16'hBEEF);
        pop();
        chk("two_rdy_end", fifo_rdy, 1'b0);
        bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 5, rd, ok, waits);
        chk("two_stat_empty", rd[2], 1'b1);

        // Backpressure: full buffer, sel=3 write stalls until a pop frees a slot
        bus(BASE + 32'h4, 1'b1, 32'hBEEF_1234, 4'hF, 5, rd, ok, waits);
        fork
            bus(BASE + 32'h4, 1'b1, 32'h0000_5555, 4'h3, 30, rd, ok, waits);
            begin
                @(negedge clk);
                repeat (10) @(posedge clk);
                #1 fifo_ack = 1'b1;
                @(posedge clk); #1 fifo_ack = 1'b0;
            end
        join
        chk("bp_ack", ok, 1'b1);
        chk("bp_waits", waits, 11);
        chk("bp_head0", fifo_o, 16'hBEEF);
        pop();
        chk("bp_head1", fifo_o, 16'h5555);
        pop();
        chk("bp_rdy_end", fifo_rdy, 1'b0);

        // CTRL byte lanes drive the DAC outputs
        bus(BASE + 32'h0, 1'b1, 32'h00A0_031D, 4'hF, 5, rd, ok, waits);
        chk("ctl_outs", {volume, psc, test_mode, osr, mute, mode},
            {8'hA0, 4'h3, 1'b1, 2'b11, 1'b0, 1'b1});
        bus(BASE + 32'h0, 1'b1, 32'h0040_0000, 4'h4, 5, rd, ok, waits);
        chk("ctl_outs_lane", {volume, psc, test_mode, osr, mute, mode},
            {8'h40, 4'h3, 1'b1, 2'b11, 1'b0, 1'b1});

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int          op;
            logic [31:0] d;
            logic [3:0]  s;
            logic [1:0]  off;
            bit          space;
            fifo_full  = 1'($urandom_range(0, 1));
            fifo_empty = 1'($urandom_range(0, 1));
            d  = $urandom;
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    s = 4'($urandom);
                    bus(BASE, 1'b1, d, s, 5, rd, ok, waits);
                    m_ctrl = ctrl_after(m_ctrl, d, s);
                    chk("rnd_ctrl_ack", ok, 1'b1);
                end
                1, 2: begin
                    case ($urandom_range(0, 3))
                        0: s = 4'hF;
                        1: s = 4'h3;
                        default: s = 4'($urandom);
                    endcase
                    space = (s == 4'hF) ? (m_q.size() == 0) :
                            (s == 4'h3) ? (m_q.size() < 2) : 1'b1;
                    bus(BASE + 32'h4, 1'b1, d, s, 4, rd, ok, waits);
                    chk("rnd_data_ack", ok, space);
                    if (space) begin
                        if (s == 4'hF) begin
                            m_q.push_back(d[15:0]);
                            m_q.push_back(d[31:16]);
                        end else if (s == 4'h3) begin
                            m_q.push_back(d[15:0]);
                        end else begin
                            m_sel_err = 1;
                        end
                    end
                end
                3: begin
                    off = 2'($urandom);
                    bus(BASE + {28'd0, off, 2'b00}, 1'b0, 32'h0, 4'hF, 5, rd, ok, waits);
                    chk("rnd_rd_ack", ok, 1'b1);
                    chk($sformatf("rnd_rd_off%0d", off), rd,
                        (off == 0) ? m_ctrl : (off == 2) ? status_exp() : 32'h0);
                end
                4: begin
                    s = 4'($urandom);
                    bus(BASE + 32'h8, 1'b1, d, s, 5, rd, ok, waits);
                    if (s[0] && d[4]) m_sel_err = 0;
                    chk("rnd_stat_ack", ok, 1'b1);
                end
                default: begin
                    pop();
                    if (m_q.size() != 0) void'(m_q.pop_front());
                end
            endcase
            chk("rnd_rdy", fifo_rdy, m_q.size() != 0);
            chk("rnd_fifo_o", fifo_o, (m_q.size() != 0) ? m_q[0] : 16'h0);
            chk("rnd_outs", {volume, psc, test_mode, osr, mute, mode},
                {m_ctrl[23:16], m_ctrl[11:8], m_ctrl[4], m_ctrl[3:2], m_ctrl[1], m_ctrl[0]});
        end

        // Reset mid-operation with a stalled request pending
        while (m_q.size() != 0) begin
            pop();
            void'(m_q.pop_front());
        end
        bus(BASE + 32'h0, 1'b1, 32'h0000_0001, 4'hF, 5, rd, ok, waits);
        bus(BASE + 32'h4, 1'b1, 32'hCAFE_F00D, 4'hF, 5, rd, ok, waits);
        @(negedge clk);
        adr = BASE + 32'h4; we = 1'b1; dat = 32'h0000_7777; sel = 4'h3;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", fifo_rdy, 1'b0);
        chk("mid_rst_ack", ack, 1'b0);
        chk("mid_rst_mute", mute, 1'b1);
        chk("mid_rst_mode", mode, 1'b0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        fifo_empty = 1'b1; fifo_full = 1'b0;
        bus(BASE + 32'h0, 1'b0, 32'h0, 4'hF, 5, rd, ok, waits);
        chk("mid_rst_ctrl", rd, 32'h0000_0002);
        bus(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 5, rd, ok, waits);
        chk("mid_rst_stat", rd, 32'h0000_0006);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
